// File: rtl/freq_meter_50m.sv
// freq_meter_50m
// Counts rising edges of an asynchronous input over a fixed gate window of
// GATE_CYCLES clock_50m cycles. With the default 1 s gate the result is in Hz.
//
// Ports:
//   clock_50m  : 50 MHz system clock, all logic on its rising edge
//   reset_n    : asynchronous active-low reset
//   enable     : 1 = measure continuously, 0 = idle (aborts a gate in progress)
//   sig_in     : signal under measurement, asynchronous to clock_50m
//   freq_count : edges counted in the last completed gate (saturating)
//   freq_valid : one-cycle pulse when freq_count/overflow update
//   overflow   : last completed gate saturated the edge counter
//   busy       : a gate window is in progress
module freq_meter_50m #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int CNT_W       = 26
) (
    input  logic             clock_50m,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_count,
    output logic             freq_valid,
    output logic             overflow,
    output logic             busy
);
    localparam int              GW        = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]   GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [0:0]      S_IDLE    = 1'b0;
    localparam logic [0:0]      S_GATE    = 1'b1;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             hist_q, hist_d;
    logic [0:0]       state_q, state_d;
    logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] freq_count_q, freq_count_d;
    logic             overflow_q, overflow_d;
    logic             valid_q, valid_d;

    logic             edge_det;
    logic             at_max;
    logic [CNT_W-1:0] cnt_next;
    logic             sat_next;

    always_comb begin
        // Synchronizer and history run in every state so the first GATE
        // cycle already sees a fresh edge indication.
        sync1_d  = sig_in;
        sync2_d  = sync1_q;
        hist_d   = sync2_q;
        edge_det = sync2_q & ~hist_q;

        // Edge count including this cycle's edge, clamped at all-ones.
        at_max   = &edge_cnt_q;
        cnt_next = (edge_det && !at_max) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;
        sat_next = sat_q | (edge_det & at_max);

        state_d      = state_q;
        gate_cnt_d   = gate_cnt_q;
        edge_cnt_d   = edge_cnt_q;
        sat_d        = sat_q;
        freq_count_d = freq_count_q;
        overflow_d   = overflow_q;
        valid_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                sat_d      = 1'b0;
                if (enable) state_d = S_GATE;
            end
            default: begin
                if (!enable) begin
                    // Abort: partial counts are discarded, results hold.
                    state_d    = S_IDLE;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                end else if (gate_cnt_q == GATE_LAST) begin
                    // Terminal cycle: publish and restart with no dead cycle.
                    freq_count_d = cnt_next;
                    overflow_d   = sat_next;
                    valid_d      = 1'b1;
                    gate_cnt_d   = '0;
                    edge_cnt_d   = '0;
                    sat_d        = 1'b0;
                end else begin
                    gate_cnt_d = gate_cnt_q + GW'(1);
                    edge_cnt_d = cnt_next;
                    sat_d      = sat_next;
                end
            end
        endcase
    end

    always_ff @(posedge clock_50m or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            hist_q       <= 1'b0;
            state_q      <= S_IDLE;
            gate_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            sat_q        <= 1'b0;
            freq_count_q <= '0;
            overflow_q   <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            hist_q       <= hist_d;
            state_q      <= state_d;
            gate_cnt_q   <= gate_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            sat_q        <= sat_d;
            freq_count_q <= freq_count_d;
            overflow_q   <= overflow_d;
            valid_q      <= valid_d;
        end
    end

    assign freq_count = freq_count_q;
    assign freq_valid = valid_q;
    assign overflow   = overflow_q;
    assign busy       = (state_q == S_GATE);

endmodule

// File: tb/tb_freq_meter_50m.sv
// Testbench for freq_meter_50m: table of periodic patterns, hand-written
// window-boundary / abort / reset sequences, then random traffic, all checked
// every cycle against a window-counting reference model.
module tb_freq_meter_50m;
    localparam int G     = 100;
    localparam int MAX26 = 67108863;

    logic        clk = 1'b0;
    logic        reset_n, enable, sig_in, sig_b;
    logic [25:0] fc;
    logic        fv, ov, bz;
    logic [2:0]  fc3;
    logic        fv3, ov3, bz3;
    logic [3:0]  fc4;
    logic        fv4, ov4, bz4;

    always #5 clk = ~clk;

    freq_meter_50m #(.GATE_CYCLES(G), .CNT_W(26)) dut (
        .clock_50m(clk), .reset_n(reset_n), .enable(enable), .sig_in(sig_in),
        .freq_count(fc), .freq_valid(fv), .overflow(ov), .busy(bz));
    freq_meter_50m #(.GATE_CYCLES(G), .CNT_W(3)) dut3 (
        .clock_50m(clk), .reset_n(reset_n), .enable(enable), .sig_in(sig_in),
        .freq_count(fc3), .freq_valid(fv3), .overflow(ov3), .busy(bz3));
    freq_meter_50m #(.GATE_CYCLES(G), .CNT_W(4)) dut4 (
        .clock_50m(clk), .reset_n(reset_n), .enable(enable), .sig_in(sig_b),
        .freq_count(fc4), .freq_valid(fv4), .overflow(ov4), .busy(bz4));

    int checks = 0;
    int errors = 0;

    // Reference model: samp[k] is the sig_in value seen by the synchronizer
    // at clock edge k (0 while reset holds it). A run of enable-high samples
    // starting at edge t0 yields a result every G edges; the result counts
    // rising samples k in [e-G-1, e-2].
    int  e = 0;
    bit  samp [65536];
    bit  run = 1'b0;
    int  t0 = 0;
    int  m_count = 0;
    bit  m_valid = 1'b0;
    bit  m_ovf = 1'b0;

    // stimulus generator: 0 periodic, 1 random, 2 manual
    int mode = 2, hi = 0, lo = 1, ph = 0, hold = 2, phb = 0;

    typedef struct {
        int hi; int lo; int cnt; int ovf; int cnt3; int ovf3;
    } row_t;
    row_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (edge %0d)", name, act, exp, e);
        end
    endtask

    function automatic int rises(input int lo_k, input int hi_k);
        int n = 0;
        for (int k = lo_k; k <= hi_k; k++)
            if (k >= 1 && samp[k] && !samp[k-1]) n++;
        return n;
    endfunction

    task automatic step();
        int n;
        @(posedge clk);
        e++;
        if (!reset_n) begin
            samp[e] = 1'b0; run = 1'b0;
            m_valid = 1'b0; m_count = 0; m_ovf = 1'b0;
        end else begin
            samp[e] = sig_in;
            m_valid = 1'b0;
            if (enable) begin
                if (!run) begin
                    run = 1'b1; t0 = e;
                end else if ((e - t0) % G == 0) begin
                    n       = rises(e - G - 1, e - 2);
                    m_count = (n > MAX26) ? MAX26 : n;
                    m_ovf   = (n > MAX26);
                    m_valid = 1'b1;
                end
            end else begin
                run = 1'b0;
            end
        end
        #1;
        chk("valid", fv, m_valid);
        chk("busy", bz, run);
        chk("count", fc, m_count);
        chk("overflow", ov, m_ovf);
        case (mode)
            0: begin sig_in = (ph < hi); ph = (ph + 1) % (hi + lo); end
            1: begin
                hold--;
                if (hold <= 0) begin sig_in = ~sig_in; hold = $urandom_range(2, 7); end
            end
            default: ;
        endcase
        sig_b = (phb < 10);
        phb   = (phb + 1) % 20;
    endtask

    task automatic set_pattern(input int h, input int l);
        mode = 0; hi = h; lo = l; ph = 0;
    endtask

    // Steps until freq_valid is seen; returns the number of steps, -1 on timeout.
    task automatic wait_valid(input int limit, output int steps);
        steps = -1;
        for (int i = 0; i < limit; i++) begin
            step();
            if (fv) begin steps = i + 1; break; end
        end
        if (steps < 0) begin
            checks++; errors++;
            $display("FAIL wait_valid no pulse within %0d cycles (edge %0d)", limit, e);
        end
    endtask

    function automatic bit pat(input int r);
        if (r >= 2*G - 1) return 1'b1;
        if (r >= 2*G - 3) return 1'b0;
        if (r >= G + 2)   return 1'b1;
        if (r >= G)       return 1'b0;
        if (r >= G - 2)   return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        int st, a2, a3, tb_t, nres, seen;
        int res [3];

        tbl[0] = '{5, 5, 10, 0, 7, 1};
        tbl[1] = '{0, 4, 0, 0, 0, 0};
        tbl[2] = '{2, 2, 25, 0, 7, 1};
        tbl[3] = '{10, 10, 5, 0, 5, 0};
        tbl[4] = '{3, 7, 10, 0, 7, 1};

        reset_n = 1'b0; enable = 1'b0; sig_in = 1'b0; sig_b = 1'b0;
        repeat (4) step();
        chk("reset_count", fc, 0);
        chk("reset_valid", fv, 0);
        chk("reset_ovf", ov, 0);
        chk("reset_busy", bz, 0);

        reset_n = 1'b1;
        repeat (3) step();
        set_pattern(5, 5);
        enable = 1'b1;
        wait_valid(G + 20, st);
        chk("first_latency", st, G + 1);

        // periodic patterns: third result is a full window of the new pattern
        for (int r = 0; r < 5; r++) begin
            set_pattern(tbl[r].hi, tbl[r].lo);
            wait_valid(G + 20, st);
            wait_valid(G + 20, st);
            a2 = e;
            wait_valid(G + 20, st);
            a3 = e;
            chk("tbl_spacing", a3 - a2, G);
            chk("tbl_count", fc, tbl[r].cnt);
            chk("tbl_ovf", ov, tbl[r].ovf);
            chk("tbl_valid3", fv3, 1);
            chk("tbl_busy3", bz3, 1);
            chk("tbl_count3", fc3, tbl[r].cnt3);
            chk("tbl_ovf3", ov3, tbl[r].ovf3);
            chk("tbl_valid4", fv4, 1);
            chk("tbl_busy4", bz4, 1);
            chk("tbl_count4", fc4, 5);
            chk("tbl_ovf4", ov4, 0);
        end

        // window boundary: edges on the terminal cycle and first cycle of a window
        enable = 1'b0; mode = 2; sig_in = 1'b0;
        repeat (5) step();
        chk("idle_busy", bz, 0);
        enable = 1'b1;
        tb_t = e + 1;
        nres = 0;
        for (int i = 0; i < 3*G + 10 && nres < 3; i++) begin
            step();
            sig_in = pat(e + 1 - tb_t);
            if (fv) begin res[nres] = fc; nres++; end
        end
        chk("bnd_results", nres, 3);
        if (nres == 3) begin
            chk("bnd_w1", res[0], 1);
            chk("bnd_w2", res[1], 1);
            chk("bnd_w3", res[2], 1);
        end

        // abort mid-gate after a result of 10
        set_pattern(5, 5);
        wait_valid(G + 20, st);
        wait_valid(G + 20, st);
        chk("abort_prior", fc, 10);
        repeat (50) step();
        enable = 1'b0;
        step();
        chk("abort_busy", bz, 0);
        seen = 0;
        for (int i = 0; i < 150; i++) begin
            step();
            if (fv) seen++;
        end
        chk("abort_no_valid", seen, 0);
        chk("abort_hold", fc, 10);
        enable = 1'b1;
        wait_valid(G + 20, st);
        chk("reenable_latency", st, G + 1);
        chk("reenable_count", fc, 10);

        // asynchronous reset mid-gate
        repeat (30) step();
        reset_n = 1'b0;
        #1;
        chk("arst_count", fc, 0);
        chk("arst_valid", fv, 0);
        chk("arst_ovf", ov, 0);
        chk("arst_busy", bz, 0);
        repeat (5) step();
        reset_n = 1'b1;
        wait_valid(G + 20, st);
        chk("rst_latency", st, G + 1);

        // random traffic with random enable drops and resets
        mode = 1; hold = 2;
        for (int i = 0; i < 4000; i++) begin
            step();
            if (enable && $urandom_range(0, 249) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 19) == 0) enable = 1'b1;
            if ($urandom_range(0, 999) == 0) begin
                reset_n = 1'b0;
                repeat (3) step();
                reset_n = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at edge %0d", e);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/freq_meter_50m.md
# freq_meter_50m

Measures the frequency of an asynchronous digital input against the 50 MHz board clock by counting its rising edges over a fixed gate window. It is the inverse of the team's clock dividers: they derive slow clocks from `clock_50m`, and this block recovers a rate from a slow signal. It feeds the seven-segment display path and self-checks of the divided clocks (100 Hz clock looped back gives a reading of 100). With the default 1 s gate, the result reads directly in Hz.

## Interface
- `GATE_CYCLES`, default 50_000_000: gate window length in `clock_50m` cycles (1 s at 50 MHz). Must be ≥ 4.
- `CNT_W`, default 26: width of the result and edge counter.
- `clock_50m`  input  1  system clock, 50 MHz; all logic on its rising edge.
- `reset_n`  input  1  reset, asynchronous assert, active-low; one clock, reset is asynchronous and active-low.
- `enable`  input  1  synchronous; high = measure continuously, low = idle.
- `sig_in`  input  1  signal under measurement; asynchronous to `clock_50m`.
- `freq_count`  output  CNT_W  edges counted in the last completed gate (registered).
- `freq_valid`  output  1  one-cycle pulse when `freq_count` updates.
- `overflow`  output  1  last completed gate saturated the edge counter.
- `busy`  output  1  high while a gate window is in progress.

## Operation
- Input path: 2-flop synchronizer on `sig_in`, then one history flop. A rising edge is detected when the synchronized value is 1 and the history value is 0.
- FSM states are IDLE and GATE.
  - IDLE: gate counter = 0, edge counter = 0, `busy` = 0. When `enable`=1 is sampled, go to GATE.
  - GATE: the gate counter increments each cycle, from 0 to GATE_CYCLES-1. Each detected edge increments the edge counter.
  - The edge counter saturates at 2^CNT_W-1 and sets an internal sat flag.
- Terminal cycle (gate counter = GATE_CYCLES-1, `enable`=1):
  - `freq_count` ← edge counter + (edge detected this cycle), saturating.
  - `overflow` ← sat flag, including saturation in this cycle.
  - `freq_valid` = 1 on the next cycle.
  - Gate counter, edge counter and sat flag clear, and the FSM stays in GATE. The next window starts with no dead cycle, so no edge is lost or double-counted between windows.
- `enable` sampled 0 in GATE (including the terminal cycle): abort to IDLE and discard partial counts. `freq_count` and `overflow` hold their old values, and no `freq_valid` is generated.
- Synchronizer flops run in every state, so edges in flight are never stale: the first edge counted is one detected in the first GATE cycle or later.
- `sig_in` must have high and low times of at least 2 clocks for exact counts. Faster signals undercount; this is allowed and not flagged.

## Timing
- Reset values: `freq_count`=0, `freq_valid`=0, `overflow`=0, `busy`=0, FSM=IDLE, all counters and synchronizer flops 0. Reset mid-gate discards everything immediately and asynchronously.
- `enable` rise at cycle t (sampled at edge t) → `busy`=1 from t+1. The gate covers cycles t+1 … t+GATE_CYCLES.
- Terminal cycle at t+GATE_CYCLES → `freq_count`/`overflow` update and `freq_valid`=1, both visible after edge t+GATE_CYCLES+1. Results then repeat every GATE_CYCLES cycles.
- `sig_in` rise → detection 3 clocks later (2 sync + 1 history). An edge detected in the cycle `enable` drops is discarded.
- `freq_valid` is exactly 1 cycle wide and never asserts in IDLE.
- `busy` falls on the cycle after `enable` is sampled low.

## Test plan
- GATE_CYCLES=100, `sig_in` period 10 clocks (5 high/5 low), `enable` held 1 → every `freq_valid` shows `freq_count`=10, `overflow`=0, pulses spaced exactly 100 cycles apart.
- Same setup, `sig_in` held 0 → `freq_count`=0 each window. `sig_in` toggling every 2 clocks (period 4) → `freq_count`=25.
- Window-boundary edge: GATE_CYCLES=100, one `sig_in` edge detected on the terminal cycle and one on the following cycle → first result 1, second result 1 (no loss, no double count).
- CNT_W=3, GATE_CYCLES=100, period 10 → `freq_count`=7, `overflow`=1. Then period 20 with CNT_W=4 → `freq_count`=5, `overflow`=0.
- Drop `enable` at gate cycle 50 after a prior result of 10 → `busy`→0, no `freq_valid`, `freq_count` stays 10. Re-enable → next result after exactly 100 cycles.
- Assert `reset_n`=0 mid-gate → all outputs 0 immediately. Release with `enable`=1 → first `freq_valid` arrives GATE_CYCLES+1 cycles after the first sampled enable.
